// File: rtl/rf_pkg.sv
// Shared defaults and types for the scoreboarded register file.
package rf_pkg;
    localparam int unsigned DATA_W_DEF   = 16;
    localparam int unsigned NUM_REGS_DEF = 8;
    localparam int unsigned ADDR_W_DEF   = $clog2(NUM_REGS_DEF);
    localparam int unsigned ZERO_REG     = 0;

    typedef logic [ADDR_W_DEF-1:0] rf_addr_t;
endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array mux plus optional same-cycle write forwarding.
module rf_read_port
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned BYPASS   = 1
) (
    input  logic [ADDR_W-1:0]   rd_addr,
    input  logic [DATA_W-1:0]   regs [NUM_REGS],
    input  logic [NUM_REGS-1:0] busy,
    input  logic                wr_en,
    input  logic [ADDR_W-1:0]   wr_addr,
    input  logic [DATA_W-1:0]   wr_data,
    output logic [DATA_W-1:0]   rd_data_c,
    output logic                rd_busy_c
);

    logic fwd_hit;

    // Forward only real writes; register 0 is never a bypass source.
    always_comb begin
        fwd_hit   = (BYPASS != 0) && wr_en && (wr_addr == rd_addr)
                    && (wr_addr != ADDR_W'(ZERO_REG));
        rd_data_c = regs[rd_addr];
        rd_busy_c = busy[rd_addr];
        if (fwd_hit) begin
            rd_data_c = wr_data;
            rd_busy_c = 1'b0;
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Register file with N read ports, write bypass, hardwired r0 and a busy scoreboard
// (issue sets, writeback clears) used by decode for hazard stalls.
module reg_file_scoreboard
    import rf_pkg::*;
#(
    parameter int unsigned DATA_W   = DATA_W_DEF,
    parameter int unsigned NUM_REGS = NUM_REGS_DEF,
    parameter int unsigned ADDR_W   = $clog2(NUM_REGS),
    parameter int unsigned NUM_RD   = 2,
    parameter int unsigned BYPASS   = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_RD*ADDR_W-1:0]   RdAddr,
    output logic [NUM_RD*DATA_W-1:0]   RdData,
    output logic [NUM_RD-1:0]          RdBusy,
    input  logic                       WrEn,
    input  logic [ADDR_W-1:0]          WrAddr,
    input  logic [DATA_W-1:0]          WrData,
    input  logic                       IssueEn,
    input  logic [ADDR_W-1:0]          IssueAddr,
    output logic                       IssueStall,
    output logic [NUM_REGS-1:0]        BusyVec,
    output logic [ADDR_W:0]            BusyCnt
);

    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0]   regs_q [NUM_REGS];
    logic [DATA_W-1:0]   regs_d [NUM_REGS];
    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;
    logic [CNT_W-1:0]    busy_cnt_q;
    logic [CNT_W-1:0]    busy_cnt_d;
    logic                wr_live;
    logic                issue_stall_c;

    // WAW stall: destination still busy and not being cleared by this cycle's writeback.
    always_comb begin
        wr_live       = WrEn && (WrAddr != ADDR_W'(ZERO_REG));
        issue_stall_c = IssueEn && (IssueAddr != ADDR_W'(ZERO_REG)) && busy_q[IssueAddr]
                        && !(wr_live && (WrAddr == IssueAddr));
    end

    // Next state: writeback first, then issue, so a same-register pair leaves busy set.
    always_comb begin
        regs_d     = regs_q;
        busy_d     = busy_q;
        busy_cnt_d = '0;
        if (wr_live) begin
            regs_d[WrAddr] = WrData;
            busy_d[WrAddr] = 1'b0;
        end
        if (IssueEn && !issue_stall_c && (IssueAddr != ADDR_W'(ZERO_REG))) begin
            busy_d[IssueAddr] = 1'b1;
        end
        regs_d[ZERO_REG] = '0;
        busy_d[ZERO_REG] = 1'b0;
        for (int unsigned r = 0; r < NUM_REGS; r++) begin
            busy_cnt_d = busy_cnt_d + CNT_W'(busy_d[ADDR_W'(r)]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            regs_q     <= '{default: '0};
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            regs_q     <= regs_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        rf_read_port #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .ADDR_W   (ADDR_W),
            .BYPASS   (BYPASS)
        ) u_port (
            .rd_addr   (RdAddr[p*ADDR_W +: ADDR_W]),
            .regs      (regs_q),
            .busy      (busy_q),
            .wr_en     (WrEn),
            .wr_addr   (WrAddr),
            .wr_data   (WrData),
            .rd_data_c (RdData[p*DATA_W +: DATA_W]),
            .rd_busy_c (RdBusy[p])
        );
    end

    always_comb begin
        IssueStall = issue_stall_c;
        BusyVec    = busy_q;
        BusyCnt    = busy_cnt_q;
    end

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench: two instances (bypass/2 ports, no-bypass/4 ports) share write and issue stimulus.
module tb_reg_file_scoreboard;

    logic        clk;
    logic        rst_n;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;
    logic        issue_en;
    logic [2:0]  issue_addr;

    logic [5:0]  rd_addr_a;
    logic [31:0] rd_data_a;
    logic [1:0]  rd_busy_a;
    logic        stall_a;
    logic [7:0]  busy_vec_a;
    logic [3:0]  busy_cnt_a;

    logic [11:0] rd_addr_b;
    logic [63:0] rd_data_b;
    logic [3:0]  rd_busy_b;
    logic        stall_b;
    logic [7:0]  busy_vec_b;
    logic [3:0]  busy_cnt_b;

    logic [63:0] sb_q [$];
    logic [63:0] e;
    int          n_cmp;
    int          n_fail;

    reg_file_scoreboard #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(2), .BYPASS(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .RdAddr(rd_addr_a), .RdData(rd_data_a), .RdBusy(rd_busy_a),
        .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .IssueEn(issue_en),
        .IssueAddr(issue_addr), .IssueStall(stall_a), .BusyVec(busy_vec_a), .BusyCnt(busy_cnt_a)
    );

    reg_file_scoreboard #(.DATA_W(16), .NUM_REGS(8), .NUM_RD(4), .BYPASS(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .RdAddr(rd_addr_b), .RdData(rd_data_b), .RdBusy(rd_busy_b),
        .WrEn(wr_en), .WrAddr(wr_addr), .WrData(wr_data), .IssueEn(issue_en),
        .IssueAddr(issue_addr), .IssueStall(stall_b), .BusyVec(busy_vec_b), .BusyCnt(busy_cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en    = 1'b0;
        issue_en = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        issue_en = 1'b1; issue_addr = 3'd3;
        rd_addr_a = '0; rd_addr_b = '0;
        tick();
        rst_n = 1'b1; idle();
        rd_addr_a = {3'd0, 3'd3};
        rd_addr_b = {3'd3, 3'd3, 3'd3, 3'd3};
        sb_q.push_back(64'h0); sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        sb_q.push_back(64'h0); sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_a[15:0] !== e[15:0]) begin n_fail++; $display("FAIL reset_r3: got %h want %h", rd_data_a[15:0], e[15:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (busy_vec_a !== e[7:0]) begin n_fail++; $display("FAIL reset_busyvec: got %h want %h", busy_vec_a, e[7:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (busy_cnt_a !== e[3:0]) begin n_fail++; $display("FAIL reset_busycnt: got %0d want %0d", busy_cnt_a, e[3:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (stall_a !== e[0]) begin n_fail++; $display("FAIL reset_stall: got %b want %b", stall_a, e[0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_busy_a !== e[1:0]) begin n_fail++; $display("FAIL reset_rdbusy: got %b want %b", rd_busy_a, e[1:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_b !== e) begin n_fail++; $display("FAIL reset_b_rd: got %h want %h", rd_data_b, e); end
    endtask

    task automatic test_write_read();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h1234;
        tick();
        idle();
        rd_addr_a = {3'd0, 3'd5};
        rd_addr_b = {3'd0, 3'd0, 3'd0, 3'd5};
        sb_q.push_back(64'h1234); sb_q.push_back(64'h1234);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_a[15:0] !== e[15:0]) begin n_fail++; $display("FAIL wr_r5_a: got %h want %h", rd_data_a[15:0], e[15:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_b[15:0] !== e[15:0]) begin n_fail++; $display("FAIL wr_r5_b: got %h want %h", rd_data_b[15:0], e[15:0]); end
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 16'hFFFF;
        rd_addr_a = {3'd0, 3'd5};
        sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_a[31:16] !== e[15:0]) begin n_fail++; $display("FAIL r0_no_bypass: got %h want %h", rd_data_a[31:16], e[15:0]); end
        tick();
        idle();
        sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_a[31:16] !== e[15:0]) begin n_fail++; $display("FAIL r0_after_wr_a: got %h want %h", rd_data_a[31:16], e[15:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_b[31:16] !== e[15:0]) begin n_fail++; $display("FAIL r0_after_wr_b: got %h want %h", rd_data_b[31:16], e[15:0]); end
    endtask

    task automatic test_bypass();
        // r2 gets 0055 while being issued in the same cycle: data lands, busy stays set
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h0055;
        issue_en = 1'b1; issue_addr = 3'd2;
        tick();
        idle();
        sb_q.push_back(64'h04);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (busy_vec_a !== e[7:0]) begin n_fail++; $display("FAIL wr_issue_same: got %h want %h", busy_vec_a, e[7:0]); end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h00AA;
        rd_addr_a = {3'd0, 3'd2};
        rd_addr_b = {3'd0, 3'd0, 3'd0, 3'd2};
        sb_q.push_back(64'h00AA); sb_q.push_back(64'h0);
        sb_q.push_back(64'h0055); sb_q.push_back(64'h1);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_a[15:0] !== e[15:0]) begin n_fail++; $display("FAIL byp_data: got %h want %h", rd_data_a[15:0], e[15:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_busy_a[0] !== e[0]) begin n_fail++; $display("FAIL byp_busy: got %b want %b", rd_busy_a[0], e[0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_b[15:0] !== e[15:0]) begin n_fail++; $display("FAIL nobyp_old_data: got %h want %h", rd_data_b[15:0], e[15:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_busy_b[0] !== e[0]) begin n_fail++; $display("FAIL nobyp_old_busy: got %b want %b", rd_busy_b[0], e[0]); end
        tick();
        idle();
        sb_q.push_back(64'h00AA); sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_b[15:0] !== e[15:0]) begin n_fail++; $display("FAIL nobyp_new_data: got %h want %h", rd_data_b[15:0], e[15:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_busy_b[0] !== e[0]) begin n_fail++; $display("FAIL nobyp_new_busy: got %b want %b", rd_busy_b[0], e[0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (busy_cnt_a !== e[3:0]) begin n_fail++; $display("FAIL byp_cnt: got %0d want %0d", busy_cnt_a, e[3:0]); end
    endtask

    task automatic test_issue();
        issue_en = 1'b1; issue_addr = 3'd4;
        sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (stall_a !== e[0]) begin n_fail++; $display("FAIL iss_first_stall: got %b want %b", stall_a, e[0]); end
        tick();
        idle();
        sb_q.push_back(64'h10); sb_q.push_back(64'h1);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (busy_vec_a !== e[7:0]) begin n_fail++; $display("FAIL iss_vec: got %h want %h", busy_vec_a, e[7:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (busy_cnt_a !== e[3:0]) begin n_fail++; $display("FAIL iss_cnt: got %0d want %0d", busy_cnt_a, e[3:0]); end
        issue_en = 1'b1; issue_addr = 3'd4;
        sb_q.push_back(64'h1); sb_q.push_back(64'h1);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (stall_a !== e[0]) begin n_fail++; $display("FAIL waw_stall_a: got %b want %b", stall_a, e[0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (stall_b !== e[0]) begin n_fail++; $display("FAIL waw_stall_b: got %b want %b", stall_b, e[0]); end
        tick();
        idle();
        sb_q.push_back(64'h1);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (busy_cnt_a !== e[3:0]) begin n_fail++; $display("FAIL waw_cnt: got %0d want %0d", busy_cnt_a, e[3:0]); end
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444;
        issue_en = 1'b1; issue_addr = 3'd4;
        sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (stall_a !== e[0]) begin n_fail++; $display("FAIL wb_iss_stall: got %b want %b", stall_a, e[0]); end
        tick();
        idle();
        rd_addr_a = {3'd0, 3'd4};
        sb_q.push_back(64'h10); sb_q.push_back(64'h4444); sb_q.push_back(64'h1);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (busy_vec_a !== e[7:0]) begin n_fail++; $display("FAIL wb_iss_vec: got %h want %h", busy_vec_a, e[7:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_a[15:0] !== e[15:0]) begin n_fail++; $display("FAIL wb_iss_data: got %h want %h", rd_data_a[15:0], e[15:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_busy_a[0] !== e[0]) begin n_fail++; $display("FAIL wb_iss_rdbusy: got %b want %b", rd_busy_a[0], e[0]); end
        issue_en = 1'b1; issue_addr = 3'd0;
        sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (stall_a !== e[0]) begin n_fail++; $display("FAIL r0_stall: got %b want %b", stall_a, e[0]); end
        tick();
        wr_en = 1'b1; wr_addr = 3'd4; wr_data = 16'h4444; issue_en = 1'b0;
        tick();
        idle();
        sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (busy_vec_a !== e[7:0]) begin n_fail++; $display("FAIL r0_never_busy: got %h want %h", busy_vec_a, e[7:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (busy_cnt_a !== e[3:0]) begin n_fail++; $display("FAIL clear_cnt: got %0d want %0d", busy_cnt_a, e[3:0]); end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 3; i++) begin
            issue_en = 1'b1; issue_addr = 3'(i);
            sb_q.push_back(64'(i));
            tick();
            e = sb_q.pop_front(); n_cmp++;
            if (busy_cnt_a !== e[3:0]) begin n_fail++; $display("FAIL b2b_cnt%0d: got %0d want %0d", i, busy_cnt_a, e[3:0]); end
        end
        idle();
        sb_q.push_back(64'h0E);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (busy_vec_a !== e[7:0]) begin n_fail++; $display("FAIL b2b_vec: got %h want %h", busy_vec_a, e[7:0]); end
        wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h2222;
        tick();
        idle();
        rd_addr_a = {3'd1, 3'd2};
        sb_q.push_back(64'h2); sb_q.push_back(64'h2);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (busy_cnt_a !== e[3:0]) begin n_fail++; $display("FAIL wb_cnt: got %0d want %0d", busy_cnt_a, e[3:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_busy_a !== e[1:0]) begin n_fail++; $display("FAIL wb_rdbusy: got %b want %b", rd_busy_a, e[1:0]); end
        // reset lands mid-operation with a write and an issue in flight
        rst_n = 1'b0; wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
        issue_en = 1'b1; issue_addr = 3'd6;
        tick();
        rst_n = 1'b1; idle();
        rd_addr_a = {3'd6, 3'd5};
        sb_q.push_back(64'h0); sb_q.push_back(64'h0); sb_q.push_back(64'h0);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (busy_cnt_a !== e[3:0]) begin n_fail++; $display("FAIL rst_cnt: got %0d want %0d", busy_cnt_a, e[3:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (busy_vec_a !== e[7:0]) begin n_fail++; $display("FAIL rst_vec: got %h want %h", busy_vec_a, e[7:0]); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_a !== e[31:0]) begin n_fail++; $display("FAIL rst_data: got %h want %h", rd_data_a, e[31:0]); end
    endtask

    task automatic test_multi_port();
        wr_en = 1'b1; wr_addr = 3'd7; wr_data = 16'h7777;
        tick();
        idle();
        rd_addr_a = {3'd7, 3'd7};
        rd_addr_b = {3'd7, 3'd7, 3'd7, 3'd7};
        sb_q.push_back({4{16'h7777}}); sb_q.push_back({2{16'h7777}});
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_b !== e) begin n_fail++; $display("FAIL mp_data_b: got %h want %h", rd_data_b, e); end
        e = sb_q.pop_front(); n_cmp++;
        if (rd_data_a !== e[31:0]) begin n_fail++; $display("FAIL mp_data_a: got %h want %h", rd_data_a, e[31:0]); end
        issue_en = 1'b1; issue_addr = 3'd7;
        tick();
        idle();
        sb_q.push_back(64'hF);
        #1;
        e = sb_q.pop_front(); n_cmp++;
        if (rd_busy_b !== e[3:0]) begin n_fail++; $display("FAIL mp_busy_b: got %b want %b", rd_busy_b, e[3:0]); end
    endtask

    initial begin
        n_cmp = 0;
        n_fail = 0;
        rst_n = 1'b0;
        idle();
        wr_addr = '0; wr_data = '0; issue_addr = '0;
        test_reset();
        test_write_read();
        test_bypass();
        test_issue();
        test_back_to_back();
        test_multi_port();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
